// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the memory port arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_DBG   = 2'd2;
  localparam int         NREQ      = 3;

  // Cyclic successor in the order fetch -> data -> dbg -> fetch
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_DBG) ? REQ_FETCH : idx + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick : combinational winner selection among the three requesters
// Options  : ARB_RR_EN selects round-robin from ptr, else data > fetch > dbg
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       valid
);

`ifdef ARB_RR_EN
  logic [1:0] idx;

  // ptr names the first requester to search from
  always_comb begin
    win   = REQ_FETCH;
    valid = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
      idx = rr_next(idx);
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win   = REQ_FETCH;
    valid = 1'b1;
    if (req[REQ_DATA]) begin
      win = REQ_DATA;
    end else if (req[REQ_FETCH]) begin
      win = REQ_FETCH;
    end else if (req[REQ_DBG]) begin
      win = REQ_DBG;
    end else begin
      valid = 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch, load/store
//                    and debug, with a watchdog that aborts unacked accesses
// Options          : ARB_RR_EN enables round-robin arbitration
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int                c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_timeout = c_wd_w'(TIMEOUT);

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [c_wd_w-1:0]   wdog_q, wdog_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic [2:0]          req_vec;
  logic [1:0]          pick_ptr;
  logic [1:0]          pick_win;
  logic                pick_valid;
  logic                busy;
  logic                done;

  assign req_vec = {dbg_req, data_req, fetch_req};

`ifdef ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pick_valid) begin
      ptr_d = rr_next(pick_win);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= REQ_FETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_ptr = REQ_FETCH;
`endif

  arb_pick u_pick (
    .req   (req_vec),
    .ptr   (pick_ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d  = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_win;
          state_d = ST_BUSY;
          case (pick_win)
            REQ_DATA: begin
              addr_d  = data_addr;
              we_d    = data_we;
              wdata_d = data_wdata;
            end
            REQ_DBG: begin
              addr_d  = dbg_addr;
              we_d    = dbg_we;
              wdata_d = dbg_wdata;
            end
            default: begin
              addr_d  = fetch_addr;
              we_d    = 1'b0;
              wdata_d = '0;
            end
          endcase
        end
      end
      ST_BUSY: begin
        // A late ack still wins over the watchdog expiring in the same cycle
        if (mem_ack) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = ST_DONE;
        end else if (wdog_q == c_timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          wdog_d = wdog_q + c_wd_w'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = REQ_FETCH;
        addr_d  = '0;
        we_d    = 1'b0;
        wdata_d = '0;
        wdog_d  = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= REQ_FETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state so nothing leaks outside BUSY/DONE
  assign busy      = (state_q == ST_BUSY);
  assign done      = (state_q == ST_DONE);
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign fetch_ack = done && (gnt_q == REQ_FETCH);
  assign data_ack  = done && (gnt_q == REQ_DATA);
  assign dbg_ack   = done && (gnt_q == REQ_DBG);
  assign err       = done & err_q;
  assign rdata     = done ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed vector bench for mem_port_arbiter
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic        fetch_ack;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [7:0]  data_addr = '0;
  logic [15:0] data_wdata = '0;
  logic        data_ack;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [15:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ack   (data_ack),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .rdata      (rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       name;
    logic        f_req;
    logic        d_req;
    logic        d_we;
    logic        g_req;
    logic        g_we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int          waitc;     // wait cycles before mem_ack; large = never
    bit          tied;      // mem_ack held high throughout
    bit          withdraw;  // drop req and scramble inputs after first BUSY cycle
    logic [2:0]  e_ack;     // {dbg, data, fetch}
    logic [15:0] e_rdata;
    logic        e_err;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    int          e_nreq;
    int          e_lat;     // rising edges from request to ack
  } vec_t;

  vec_t vecs[9];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drop_all();
    fetch_req = 1'b0;
    data_req  = 1'b0;
    dbg_req   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc   = 0;
    int          n_req = 0;
    int          bad   = 0;
    int          lat   = -1;
    logic [2:0]  ack_v = '0;
    logic [15:0] rd    = '0;
    logic        er    = 1'b0;
    bit          got   = 1'b0;
    @(negedge clk);
    fetch_req  = v.f_req;
    data_req   = v.d_req;
    data_we    = v.d_we;
    dbg_req    = v.g_req;
    dbg_we     = v.g_we;
    fetch_addr = v.addr;
    data_addr  = v.addr;
    dbg_addr   = v.addr;
    data_wdata = v.wdata;
    dbg_wdata  = v.wdata;
    mem_rdata  = v.mrdata;
    mem_ack    = v.tied;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req) begin
        n_req++;
        if ({mem_we, mem_addr, mem_wdata} !== {v.e_we, v.e_addr, v.e_wdata}) bad++;
        if (v.withdraw && n_req == 1) begin
          drop_all();
          fetch_addr = 8'h5A;
          data_addr  = 8'h5A;
          dbg_addr   = 8'h5A;
          data_wdata = 16'h5A5A;
          dbg_wdata  = 16'h5A5A;
          data_we    = ~v.d_we;
          dbg_we     = ~v.g_we;
        end
        mem_ack = v.tied || (n_req == v.waitc + 1);
      end else if ({dbg_ack, data_ack, fetch_ack} != 3'b000) begin
        got   = 1'b1;
        lat   = cyc;
        ack_v = {dbg_ack, data_ack, fetch_ack};
        rd    = rdata;
        er    = err;
      end
    end
    drop_all();
    mem_ack = 1'b0;
    check({v.name, "_got_ack"}, 64'(got), 64'd1);
    check({v.name, "_mem_req_cycles"}, 64'(n_req), 64'(v.e_nreq));
    check({v.name, "_mem_fields_bad_cycles"}, 64'(bad), 64'd0);
    check({v.name, "_latency"}, 64'(lat), 64'(v.e_lat));
    check({v.name, "_ack_vec"}, 64'(ack_v), 64'(v.e_ack));
    check({v.name, "_rdata"}, 64'(rd), 64'(v.e_rdata));
    check({v.name, "_err"}, 64'(er), 64'(v.e_err));
    @(posedge clk);
    #1;
    check({v.name, "_post_idle"},
          64'({fetch_ack, data_ack, dbg_ack, err, mem_req, rdata}), 64'd0);
  endtask

  initial begin
    int          ord[3];
    int          tms[3];
    int          exp_ord[3];
    int          n_g;
    int          e;
    int          stray;

`ifdef ARB_RR_EN
    exp_ord = '{0, 1, 2};
`else
    exp_ord = '{1, 0, 2};
`endif

    //          name              f  d  dwe g  gwe addr   wdata     mrdata    wait tied wd   ack     rdata     err we  addr   wdata     nreq lat
    vecs[0] = '{"fetch_rd",       1, 0, 0,  0, 0,  8'h10, 16'h0000, 16'hBEEF, 0,   1,   0,   3'b001, 16'hBEEF, 0,  0,  8'h10, 16'h0000, 1,   2};
    vecs[1] = '{"store_w2",       0, 1, 1,  0, 0,  8'h20, 16'h1234, 16'h9999, 2,   0,   0,   3'b010, 16'h0000, 0,  1,  8'h20, 16'h1234, 3,   4};
    vecs[2] = '{"load_w1",        0, 1, 0,  0, 0,  8'h33, 16'h0000, 16'hA5A5, 1,   0,   0,   3'b010, 16'hA5A5, 0,  0,  8'h33, 16'h0000, 2,   3};
    vecs[3] = '{"dbg_wr",         0, 0, 0,  1, 1,  8'hFF, 16'hCAFE, 16'h1111, 0,   0,   0,   3'b100, 16'h0000, 0,  1,  8'hFF, 16'hCAFE, 1,   2};
    vecs[4] = '{"dbg_rd_w14",     0, 0, 0,  1, 0,  8'h01, 16'h0000, 16'h1357, 14,  0,   0,   3'b100, 16'h1357, 0,  0,  8'h01, 16'h0000, 15,  16};
    vecs[5] = '{"dbg_timeout",    0, 0, 0,  1, 0,  8'h42, 16'h0000, 16'hFFFF, 999, 0,   0,   3'b100, 16'h0000, 1,  0,  8'h42, 16'h0000, 16,  17};
    vecs[6] = '{"dbg_after_to",   0, 0, 0,  1, 0,  8'h43, 16'h0000, 16'h2468, 0,   0,   0,   3'b100, 16'h2468, 0,  0,  8'h43, 16'h0000, 1,   2};
    vecs[7] = '{"data_withdraw",  0, 1, 1,  0, 0,  8'h55, 16'hABCD, 16'h0000, 3,   0,   1,   3'b010, 16'h0000, 0,  1,  8'h55, 16'hABCD, 4,   5};
    vecs[8] = '{"fetch_rd_w5",    1, 0, 0,  0, 0,  8'h80, 16'h0000, 16'h0F0F, 5,   0,   0,   3'b001, 16'h0F0F, 0,  0,  8'h80, 16'h0000, 6,   7};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({fetch_ack, data_ack, dbg_ack, err, mem_req, mem_we, mem_addr, mem_wdata, rdata}),
          64'd0);
    rst = 1'b1;

    // All three requesting at once, each held until its own ack
    @(negedge clk);
    fetch_addr = 8'h01;
    data_addr  = 8'h02;
    dbg_addr   = 8'h03;
    data_we    = 1'b0;
    dbg_we     = 1'b0;
    mem_rdata  = 16'h0000;
    mem_ack    = 1'b1;
    fetch_req  = 1'b1;
    data_req   = 1'b1;
    dbg_req    = 1'b1;
    n_g = 0;
    e   = 0;
    while (n_g < 3 && e < 30) begin
      @(posedge clk);
      #1;
      e++;
      if (fetch_ack) begin ord[n_g] = 0; tms[n_g] = e; n_g++; fetch_req = 1'b0; end
      else if (data_ack) begin ord[n_g] = 1; tms[n_g] = e; n_g++; data_req = 1'b0; end
      else if (dbg_ack) begin ord[n_g] = 2; tms[n_g] = e; n_g++; dbg_req = 1'b0; end
    end
    drop_all();
    mem_ack = 1'b0;
    check("prio_grant_count", 64'(n_g), 64'd3);
    if (n_g == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("prio_order_%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
      check("prio_spacing_1", 64'(tms[1] - tms[0]), 64'd3);
      check("prio_spacing_2", 64'(tms[2] - tms[1]), 64'd3);
    end
    @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset asserted mid-access
    @(negedge clk);
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 8'h66;
    mem_ack   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_precond_busy", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_mem_req_async", 64'(mem_req), 64'd0);
    data_req = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (fetch_ack || data_ack || dbg_ack || mem_req || err) stray++;
    end
    check("rst_mid_no_ack_after", 64'(stray), 64'd0);
    run_vec(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the processor's single-port memory between three requesters: instruction fetch, load/store data access, and an external debug port. It sits between the multi-cycle control/datapath and the unified memory. Each access is granted one at a time, and the block holds the memory request until the memory acknowledges. A watchdog aborts accesses the memory never acknowledges.

## Interface
- AW, 8: address width
- DW, 16: data width
- TIMEOUT, 15: maximum BUSY cycles without `mem_ack` before abort; must be ≥1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request; read-only
- fetch_addr  in  AW  fetch address
- fetch_ack  out  1  one-cycle completion pulse
- data_req, data_we  in  1 each  load/store request; `data_we`=1 means store
- data_addr, data_wdata  in  AW, DW  load/store address and write data
- data_ack  out  1  completion pulse
- dbg_req, dbg_we  in  1 each  debug request and write enable
- dbg_addr, dbg_wdata  in  AW, DW  debug address and write data
- dbg_ack  out  1  completion pulse
- rdata  out  DW  read data, shared by all requesters; valid in the ack cycle
- err  out  1  timeout flag; pulses together with the ack of an aborted access
- mem_req, mem_we  out  1 each  memory strobe and write enable
- mem_addr, mem_wdata  out  AW, DW  memory address and write data
- mem_ack  in  1  memory completion
- mem_rdata  in  DW  memory read data; valid when `mem_ack`=1

## Operation
- **State machine:** IDLE, BUSY, DONE; 2-bit encoding IDLE=0, BUSY=1, DONE=2.
- **IDLE:**
  - If any request is high, pick a winner.
  - Latch its index (`gnt`), address, write enable and wdata into registers.
  - Clear the watchdog and go to BUSY.
  - If no request is high, stay in IDLE.
- **BUSY:**
  - Assert `mem_req` and drive the latched `mem_we`, `mem_addr` and `mem_wdata`.
  - Fetch accesses always have `mem_we`=0.
  - On `mem_ack`: register `mem_rdata` into `rdata` (reads only; writes leave `rdata`=0) and go to DONE.
  - Otherwise increment the watchdog.
  - When the watchdog equals TIMEOUT and there is still no `mem_ack`: set `err_q`, set `rdata`=0 and go to DONE.
- **DONE:**
  - Pulse the winner's `*_ack` for exactly one cycle; `err` = `err_q`.
  - Return to IDLE, clear `err_q`, and clear `rdata` on the following cycle.
- **Request handling:**
  - Requesters hold `*_req` until their ack.
  - Deasserting `*_req` mid-access does not cancel the access: it completes and is still acked.
  - A requester whose `req` is still high in IDLE after its ack starts a new access.
  - Inputs are latched only in IDLE; changes during BUSY are ignored.
- **Fixed priority (default):** data > fetch > dbg.
- **Invalid state encoding (3):** recovers to IDLE next cycle with all outputs 0.
- **Watchdog width:** $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- **Reset values:** all outputs 0, state IDLE, watchdog 0. Round-robin pointer = fetch (only when `ARB_RR_EN` is defined).
- **Reset mid-access:** returns to IDLE immediately; `mem_req` drops asynchronously; no ack is issued.
- **Access sequence:**
  - Request seen in IDLE at edge N.
  - `mem_req` high from cycle N+1.
  - `mem_ack` sampled at edge N+1+k, where k is the number of wait cycles, 0..TIMEOUT-1.
  - `*_ack`, `rdata` and `err` valid in cycle N+2+k.
- **Minimum latency:** request to ack is 3 cycles when `mem_ack` is combinational. One access takes 3+k cycles; back-to-back accesses sustain one per 3+k cycles.
- **Timeout:** `mem_req` is high for TIMEOUT+1 cycles, then DONE follows with `err`=1.
- **mem_ack outside BUSY:** ignored.
- **Output registers:** all outputs are registered or decoded from state; no combinational path from `*_req` to `mem_*`.

## Configuration
- **`ARB_RR_EN` defined:** round-robin among the three requesters.
  - Search order starts at the requester after the last winner, in cyclic order fetch → data → dbg → fetch.
  - The pointer updates only when a grant is taken in IDLE.
- **`ARB_RR_EN` undefined:** fixed priority data > fetch > dbg; no pointer register exists.

## Structure
- **Package `mem_arb_pkg`:**
  - State encoding constants.
  - Requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_DBG=2.
  - NREQ=3.
- **Sub-module `arb_pick`:** combinational winner selection. Inputs are the 3-bit request vector and the pointer; output is a 2-bit winner index plus a valid flag. Its round-robin logic is compiled under `ARB_RR_EN`.
- **Top level:** holds the FSM, the latched request registers, the watchdog and the output registers.

## Test plan
- **Fetch read with combinational memory:**
  - Stimulus: `fetch_req`=1, `fetch_addr`=0x10, `mem_ack` tied high, `mem_rdata`=0xBEEF.
  - Required: `mem_req` high one cycle with `mem_addr`=0x10 and `mem_we`=0; `fetch_ack`=1 and `rdata`=0xBEEF exactly 3 cycles after the request.
- **Store with wait states:**
  - Stimulus: `data_req`=1, `data_we`=1, addr 0x20, wdata 0x1234; `mem_ack` after 2 wait cycles.
  - Required: `mem_req` high 3 cycles with stable addr/wdata; `data_ack` at request+5; `rdata`=0; `err`=0.
- **Simultaneous requests, fixed priority:**
  - Stimulus: fetch, data and dbg all request in the same cycle, held; `ARB_RR_EN` undefined.
  - Required: grant order data, fetch, dbg, each 3 cycles apart.
- **Round-robin fairness:**
  - Stimulus: `ARB_RR_EN` defined; all three requests held high continuously.
  - Required: grants rotate fetch, data, dbg, fetch…; no requester is granted twice before the others.
- **Timeout:**
  - Stimulus: TIMEOUT=15, `dbg_req`, `mem_ack` never asserted.
  - Required: `mem_req` high 16 cycles; then `dbg_ack`=1, `err`=1, `rdata`=0 for one cycle; next `dbg_req` proceeds normally.
- **Reset and request withdrawal:**
  - Stimulus: drive `rst` low while BUSY.
  - Required: `mem_req`=0 immediately; no ack; FSM in IDLE.
  - Stimulus: withdraw `data_req` during BUSY.
  - Required: the access still completes and `data_ack` still pulses.
